// File: rtl/ir_order_rx.sv
// NEC infrared remote receiver: synchronizes and deglitches the receiver pin,
// measures pulse widths in 10 us ticks and decodes frames into OSD key codes.
module ir_order_rx #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned GLITCH_CYC  = 16,
    parameter bit          ADDR_CHECK  = 1'b0,
    parameter logic [7:0]  DEV_ADDR    = 8'h00,
    parameter bit          REPEAT_EN   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ir_in,
    output logic [7:0] order,
    output logic       order_en,
    output logic       busy,
    output logic       frame_err
);

    localparam int unsigned TICK_DIV =
        (CLK_FREQ_HZ / 100_000 > 0) ? CLK_FREQ_HZ / 100_000 : 1;
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYC - 1);

    // 120 ms of silence in 10 us ticks
    localparam logic [13:0] IDLE_LIMIT = 14'd12000;
    localparam logic [11:0] DUR_MAX    = 12'hFFF;

    localparam logic [11:0] LEAD_LO = 12'd800;
    localparam logic [11:0] LEAD_HI = 12'd1000;
    localparam logic [11:0] HDR_LO  = 12'd400;
    localparam logic [11:0] HDR_HI  = 12'd500;
    localparam logic [11:0] RPT_LO  = 12'd200;
    localparam logic [11:0] RPT_HI  = 12'd250;
    localparam logic [11:0] BURST_LO = 12'd40;
    localparam logic [11:0] BURST_HI = 12'd70;
    localparam logic [11:0] ONE_LO  = 12'd140;
    localparam logic [11:0] ONE_HI  = 12'd190;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD_L = 3'd1,
        LEAD_H = 3'd2,
        BIT_L  = 3'd3,
        BIT_H  = 3'd4,
        STOP_L = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    logic          sync1_q;
    logic          sync2_q;
    logic          irf_q;
    logic          irf_prev_q;
    logic [GW-1:0] glitch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            irf_q      <= 1'b1;
            irf_prev_q <= 1'b1;
            glitch_q   <= '0;
        end else begin
            sync1_q    <= ir_in;
            sync2_q    <= sync1_q;
            irf_prev_q <= irf_q;
            if (sync2_q != irf_q) begin
                if (glitch_q == GLITCH_LAST) begin
                    irf_q    <= sync2_q;
                    glitch_q <= '0;
                end else begin
                    glitch_q <= glitch_q + GW'(1);
                end
            end else begin
                glitch_q <= '0;
            end
        end
    end

    logic rise;
    logic fall;
    logic ir_edge;

    assign rise    = irf_q & ~irf_prev_q;
    assign fall    = ~irf_q & irf_prev_q;
    assign ir_edge = rise | fall;

    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt_q;
    logic          tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

    state_t      state_q;
    state_t      state_d;
    logic [11:0] dur_q;
    logic [13:0] idle_q;

    // An edge restarts the measurement, so a coincident tick is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_q <= '0;
        end else if (ir_edge) begin
            dur_q <= '0;
        end else if (tick && dur_q != DUR_MAX) begin
            dur_q <= dur_q + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if (state_q != IDLE || ir_edge) begin
            idle_q <= '0;
        end else if (tick && idle_q != IDLE_LIMIT) begin
            idle_q <= idle_q + 14'd1;
        end
    end

    // ------------------------------------------------------------------
    function automatic logic in_win(
        input logic [11:0] d,
        input logic [11:0] lo,
        input logic [11:0] hi
    );
        return (d >= lo) && (d <= hi);
    endfunction

    logic [4:0]  bitcnt_q;
    logic [4:0]  bitcnt_d;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic        rpt_q;
    logic        rpt_d;
    logic [7:0]  order_q;
    logic [7:0]  order_d;
    logic        order_en_q;
    logic        order_en_d;
    logic        frame_err_q;
    logic        frame_err_d;
    logic        last_valid_q;
    logic        last_valid_d;

    logic win_burst;
    logic win_one;
    logic frame_ok;

    assign win_burst = in_win(dur_q, BURST_LO, BURST_HI);
    assign win_one   = in_win(dur_q, ONE_LO, ONE_HI);

    assign frame_ok = ((data_q[23:16] ^ data_q[31:24]) == 8'hFF)
                   && ((data_q[7:0] ^ data_q[15:8]) == 8'hFF)
                   && (!ADDR_CHECK || data_q[7:0] == DEV_ADDR);

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        data_d       = data_q;
        rpt_d        = rpt_q;
        order_d      = order_q;
        order_en_d   = 1'b0;
        frame_err_d  = 1'b0;
        last_valid_d = last_valid_q;

        if (state_q == IDLE && idle_q == IDLE_LIMIT) begin
            last_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = LEAD_L;
                end
            end
            LEAD_L: begin
                if (rise) begin
                    if (in_win(dur_q, LEAD_LO, LEAD_HI)) begin
                        state_d = LEAD_H;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end else if (dur_q > LEAD_HI) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            LEAD_H: begin
                if (fall) begin
                    if (in_win(dur_q, HDR_LO, HDR_HI)) begin
                        bitcnt_d = '0;
                        rpt_d    = 1'b0;
                        state_d  = BIT_L;
                    end else if (in_win(dur_q, RPT_LO, RPT_HI)) begin
                        rpt_d   = 1'b1;
                        state_d = STOP_L;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end else if (dur_q > HDR_HI) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            BIT_L: begin
                if (rise) begin
                    if (win_burst) begin
                        state_d = BIT_H;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end else if (dur_q > BURST_HI) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            BIT_H: begin
                if (fall) begin
                    if (win_burst || win_one) begin
                        // LSB-first: the first bit ends up in data[0]
                        data_d   = {win_one, data_q[31:1]};
                        bitcnt_d = bitcnt_q + 5'd1;
                        state_d  = (bitcnt_q == 5'd31) ? STOP_L : BIT_L;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end else if (dur_q > ONE_HI) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            STOP_L: begin
                if (rise) begin
                    state_d = IDLE;
                    if (!win_burst) begin
                        frame_err_d = 1'b1;
                    end else if (rpt_q) begin
                        order_en_d = REPEAT_EN && last_valid_q;
                    end else if (frame_ok) begin
                        order_d      = data_q[23:16];
                        order_en_d   = 1'b1;
                        last_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (dur_q > BURST_HI) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            data_q       <= '0;
            rpt_q        <= 1'b0;
            order_q      <= 8'h00;
            order_en_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            last_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            data_q       <= data_d;
            rpt_q        <= rpt_d;
            order_q      <= order_d;
            order_en_q   <= order_en_d;
            frame_err_q  <= frame_err_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign order     = order_q;
    assign order_en  = order_en_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ir_order_rx.sv
// Directed bench for ir_order_rx: three parameter variants share one IR line;
// one clk equals one 10 us tick so whole NEC frames stay short.
module tb_ir_order_rx;

    logic clk;
    logic rst_n;
    logic ir_in;

    logic [7:0] rep_order, nr_order, ac_order;
    logic       rep_en, nr_en, ac_en;
    logic       rep_busy, nr_busy, ac_busy;
    logic       rep_err, nr_err, ac_err;

    int checks   = 0;
    int failures = 0;

    int en_rep = 0, err_rep = 0;
    int en_nr  = 0, err_nr  = 0;
    int en_ac  = 0, err_ac  = 0;
    int both   = 0;

    ir_order_rx #(
        .CLK_FREQ_HZ(100_000), .GLITCH_CYC(4),
        .ADDR_CHECK(1'b0), .DEV_ADDR(8'h00), .REPEAT_EN(1'b1)
    ) u_rep (
        .clk(clk), .rst_n(rst_n), .ir_in(ir_in),
        .order(rep_order), .order_en(rep_en),
        .busy(rep_busy), .frame_err(rep_err)
    );

    ir_order_rx #(
        .CLK_FREQ_HZ(100_000), .GLITCH_CYC(4),
        .ADDR_CHECK(1'b0), .DEV_ADDR(8'h00), .REPEAT_EN(1'b0)
    ) u_nr (
        .clk(clk), .rst_n(rst_n), .ir_in(ir_in),
        .order(nr_order), .order_en(nr_en),
        .busy(nr_busy), .frame_err(nr_err)
    );

    ir_order_rx #(
        .CLK_FREQ_HZ(100_000), .GLITCH_CYC(4),
        .ADDR_CHECK(1'b1), .DEV_ADDR(8'h00), .REPEAT_EN(1'b0)
    ) u_ac (
        .clk(clk), .rst_n(rst_n), .ir_in(ir_in),
        .order(ac_order), .order_en(ac_en),
        .busy(ac_busy), .frame_err(ac_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rep_en) en_rep <= en_rep + 1;
        if (rep_err) err_rep <= err_rep + 1;
        if (nr_en) en_nr <= en_nr + 1;
        if (nr_err) err_nr <= err_nr + 1;
        if (ac_en) en_ac <= en_ac + 1;
        if (ac_err) err_ac <= err_ac + 1;
        if ((rep_en && rep_err) || (nr_en && nr_err) || (ac_en && ac_err))
            both <= both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_low(input int n);
        ir_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_high(input int n);
        ir_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] mk(input logic [7:0] addr,
                                       input logic [7:0] cmd,
                                       input logic [7:0] cmd_n);
        return {cmd_n, cmd, ~addr, addr};
    endfunction

    // Leaves ir_in high right after the stop burst; caller waits for decode
    task automatic send_frame(input logic [31:0] d, input int gl_bit);
        send_low(900);
        send_high(450);
        for (int i = 0; i < 32; i++) begin
            send_low(56);
            if (i == gl_bit) begin
                send_high(20);
                send_low(3);
                send_high(d[i] ? 146 : 33);
            end else begin
                send_high(d[i] ? 169 : 56);
            end
        end
        send_low(56);
        ir_in = 1'b1;
    endtask

    int e0, r0, n0, m0, a0, b0;
    logic [31:0] part;

    initial begin
        rst_n = 1'b0;
        ir_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_order", rep_order, 8'h00);
        chk("rst_en", rep_en, 1'b0);
        chk("rst_busy", rep_busy, 1'b0);
        chk("rst_err", rep_err, 1'b0);
        rst_n = 1'b1;
        send_high(20);

        // nominal 0x2B frame with exact latency
        e0 = en_rep; r0 = err_rep;
        send_frame(mk(8'h00, 8'h2B, 8'hD4), -1);
        repeat (6) @(posedge clk);
        #1 chk("lat_early", rep_en, 1'b0);
        @(posedge clk);
        #1 chk("lat_en", rep_en, 1'b1);
        chk("lat_order", rep_order, 8'h2B);
        send_high(20);
        chk("nom_en_cnt", en_rep - e0, 1);
        chk("nom_err_cnt", err_rep - r0, 0);
        chk("nom_busy", rep_busy, 1'b0);
        chk("nom_ac_order", ac_order, 8'h2B);

        // bad command complement
        e0 = en_rep; r0 = err_rep;
        send_frame(mk(8'h00, 8'h2F, 8'hD1), -1);
        send_high(30);
        chk("badc_en_cnt", en_rep - e0, 0);
        chk("badc_err_cnt", err_rep - r0, 1);
        chk("badc_order", rep_order, 8'h2B);

        // valid 0x2C then repeat 40 ms later
        send_frame(mk(8'h00, 8'h2C, 8'hD3), -1);
        send_high(30);
        chk("rpt_first", rep_order, 8'h2C);
        e0 = en_rep; r0 = err_rep; n0 = en_nr; m0 = err_nr;
        send_high(4000);
        send_low(900);
        send_high(225);
        send_low(56);
        send_high(30);
        chk("rpt_en_cnt", en_rep - e0, 1);
        chk("rpt_err_cnt", err_rep - r0, 0);
        chk("rpt_order", rep_order, 8'h2C);
        chk("norpt_en_cnt", en_nr - n0, 0);
        chk("norpt_err_cnt", err_nr - m0, 0);
        chk("norpt_order", nr_order, 8'h2C);

        // idle glitches, then a glitch inside a bit-high period
        r0 = err_rep; e0 = en_rep;
        send_low(2);
        send_high(30);
        send_low(2);
        send_high(30);
        chk("glitch_busy", rep_busy, 1'b0);
        chk("glitch_err", err_rep - r0, 0);
        send_frame(mk(8'h00, 8'h2D, 8'hD2), 5);
        send_high(30);
        chk("glitch_order", rep_order, 8'h2D);
        chk("glitch_en_cnt", en_rep - e0, 1);
        chk("glitch_err2", err_rep - r0, 0);

        // 12 ms lead: timeout at dur 1001
        r0 = err_rep; e0 = en_rep;
        send_low(500);
        chk("long_busy", rep_busy, 1'b1);
        chk("long_err_early", err_rep - r0, 0);
        send_low(700);
        chk("long_err_cnt", err_rep - r0, 1);
        chk("long_busy_after", rep_busy, 1'b0);
        send_high(100);
        send_frame(mk(8'h00, 8'h0B, 8'hF4), -1);
        send_high(30);
        chk("long_next_order", rep_order, 8'h0B);
        chk("long_en_cnt", en_rep - e0, 1);
        chk("long_err_final", err_rep - r0, 1);

        // reset during bit 15
        e0 = en_rep; r0 = err_rep;
        part = mk(8'h00, 8'h30, 8'hCF);
        send_low(900);
        send_high(450);
        for (int i = 0; i < 15; i++) begin
            send_low(56);
            send_high(part[i] ? 169 : 56);
        end
        send_low(30);
        rst_n = 1'b0;
        ir_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("mrst_order", rep_order, 8'h00);
        chk("mrst_busy", rep_busy, 1'b0);
        chk("mrst_en_cnt", en_rep - e0, 0);
        chk("mrst_err_cnt", err_rep - r0, 0);
        rst_n = 1'b1;
        send_high(100);
        send_frame(part, -1);
        send_high(30);
        chk("mrst_next_order", rep_order, 8'h30);
        chk("mrst_next_en", en_rep - e0, 1);

        // address 0x04: rejected only by the address-checking variant
        e0 = en_rep; a0 = en_ac; b0 = err_ac;
        send_frame(mk(8'h04, 8'h09, 8'hF6), -1);
        send_high(30);
        chk("addr_ac_err", err_ac - b0, 1);
        chk("addr_ac_en", en_ac - a0, 0);
        chk("addr_ac_order", ac_order, 8'h30);
        chk("addr_rep_order", rep_order, 8'h09);
        chk("addr_rep_en", en_rep - e0, 1);

        chk("never_both", both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
